// File: rtl/fp_div_issue_queue_if.sv
// Handshake bundle for fp_div_issue_queue: operand input port, divider port and result port.
interface fp_div_issue_queue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             div_en;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      div_result;
    logic             div_ready;
    logic             div_nan;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_nan;
    logic [TAG_W-1:0] res_tag;
    logic             res_timeout;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, div_result, div_ready, div_nan, res_ready,
        output in_ready, div_en, div_a, div_b, res_valid, res_data, res_nan, res_tag, res_timeout
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, div_result, div_ready, div_nan, res_ready,
        input  in_ready, div_en, div_a, div_b, res_valid, res_data, res_nan, res_tag, res_timeout
    );
endinterface

// File: rtl/fp_div_issue_queue.sv
// Operand FIFO plus one-op-in-flight issue FSM in front of the FP32 divider.
// Optional completion timeout is built when DIV_ISSUE_TIMEOUT_EN is defined.
module fp_div_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    fp_div_issue_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic [31:0]      a_mem [DEPTH];
    logic [31:0]      b_mem [DEPTH];
    logic [TAG_W-1:0] t_mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             div_en_q, div_en_d;
    logic [31:0]      div_a_q, div_a_d, div_b_q, div_b_d;
    logic [TAG_W-1:0] tag_q, tag_d, res_tag_q, res_tag_d;
    logic             res_valid_q, res_valid_d, res_nan_q, res_nan_d;
    logic [31:0]      res_data_q, res_data_d;
    logic             push, pop, done;

`ifdef DIV_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             res_to_q, res_to_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    assign push = bus.in_valid && in_ready_q;
    // The head is registered on entry to ISSUE so operands are valid alongside div_en.
    assign pop  = (state_q == IDLE) && (count_q != '0);
    assign done = bus.div_ready || bus.div_nan;

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q] <= bus.in_a;
            b_mem[wr_ptr_q] <= bus.in_b;
            t_mem[wr_ptr_q] <= bus.in_tag;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        div_en_d    = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        tag_d       = tag_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_nan_d   = res_nan_q;
        res_tag_d   = res_tag_q;
`ifdef DIV_ISSUE_TIMEOUT_EN
        tmo_d       = tmo_q;
        res_to_d    = res_to_q;
`endif
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d    = count_q + CW'(push) - CW'(pop);
        in_ready_d = (count_d != CW'(DEPTH));

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d  = ISSUE;
                    div_en_d = 1'b1;
                    div_a_d  = a_mem[rd_ptr_q];
                    div_b_d  = b_mem[rd_ptr_q];
                    tag_d    = t_mem[rd_ptr_q];
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef DIV_ISSUE_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT: begin
                // NaN wins when both pulses land together.
                if (done) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_data_d  = bus.div_result;
                    res_nan_d   = bus.div_nan;
                    res_tag_d   = tag_q;
`ifdef DIV_ISSUE_TIMEOUT_EN
                    res_to_d    = 1'b0;
`endif
                end
`ifdef DIV_ISSUE_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d     = RESP;
                    res_valid_d = 1'b1;
                    res_data_d  = 32'h7FC0_0000;
                    res_nan_d   = 1'b1;
                    res_tag_d   = tag_q;
                    res_to_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            div_en_q    <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_nan_q   <= 1'b0;
            res_tag_q   <= '0;
`ifdef DIV_ISSUE_TIMEOUT_EN
            tmo_q       <= '0;
            res_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            div_en_q    <= div_en_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_nan_q   <= res_nan_d;
            res_tag_q   <= res_tag_d;
`ifdef DIV_ISSUE_TIMEOUT_EN
            tmo_q       <= tmo_d;
            res_to_q    <= res_to_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.div_en    = div_en_q;
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_nan   = res_nan_q;
    assign bus.res_tag   = res_tag_q;
`ifdef DIV_ISSUE_TIMEOUT_EN
    assign bus.res_timeout = res_to_q;
`else
    assign bus.res_timeout = 1'b0;
`endif
endmodule
